// File: rtl/scan_host_pkg.sv
// Shared definitions for the host-side encrypted scan driver.
//   - state_e        : driver sequencing states
//   - DEF_*          : default vector width, chain length, die-side decrypt
//                      latency and cipher timeout
//   - max4           : elaboration-time helper used to size the cycle counter
package scan_host_pkg;

  localparam int DEF_W         = 128;
  localparam int DEF_CHAIN_LEN = 128;
  localparam int DEF_LAT       = 23;
  localparam int DEF_CIPHER_TO = 1023;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ENC,
    S_TX,
    S_WAIT,
    S_LOAD,
    S_UPD,
    S_CAP,
    S_RX,
    S_DEC,
    S_RESP
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/scan_host_shreg.sv
// Shared TX/RX shift register.
//   tck        : clock (posedge)
//   load       : parallel load of load_data (highest priority)
//   shift_out  : shift left, zero fill (MSB is presented on TDI by the parent)
//   shift_in   : shift left, sin enters at the LSB
//   load_data  : parallel load value
//   sin        : serial input bit
//   q          : register contents
// Pure datapath: no reset, the parent gates everything it exposes.
module scan_host_shreg #(
  parameter int W = 128
) (
  input  logic         tck,
  input  logic         load,
  input  logic         shift_out,
  input  logic         shift_in,
  input  logic [W-1:0] load_data,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift_out) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
    end else if (shift_in) begin
      shreg_d = {shreg_q[W-2:0], sin};
    end
  end

  always_ff @(posedge tck) begin
    shreg_q <= shreg_d;
  end

  assign q = shreg_q;

endmodule

// File: rtl/scan_host_crypt_driver.sv
// Host-side driver for the encrypted scan path.
// A plaintext vector is accepted, encrypted by an external cipher, shifted
// MSB-first onto TDI, then the die-side TDR is sequenced (load shift, update,
// capture, response shift), the response collected from TDO is decrypted by
// the external cipher and presented on resp_data with a valid/ready handshake.
// Ports:
//   tck, reset                 : clock, async active-high reset
//   vec_valid/vec_ready/vec_data : plaintext vector input handshake
//   enc_start/enc_in/enc_done/enc_out : encrypt cipher interface
//   dec_start/dec_in/dec_done/dec_out : decrypt cipher interface
//   TDI, TDO                   : serial scan data
//   shift_en/update_en/capture_en : TDR controls (at most one high)
//   resp_valid/resp_ready/resp_data/resp_err : response output handshake
module scan_host_crypt_driver
  import scan_host_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int LAT       = DEF_LAT,
  parameter int CIPHER_TO = DEF_CIPHER_TO
) (
  input  logic         tck,
  input  logic         reset,
  input  logic         vec_valid,
  output logic         vec_ready,
  input  logic [W-1:0] vec_data,
  output logic         enc_start,
  output logic [W-1:0] enc_in,
  input  logic         enc_done,
  input  logic [W-1:0] enc_out,
  output logic         dec_start,
  output logic [W-1:0] dec_in,
  input  logic         dec_done,
  input  logic [W-1:0] dec_out,
  output logic         TDI,
  input  logic         TDO,
  output logic         shift_en,
  output logic         update_en,
  output logic         capture_en,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_err
);

  localparam int CNT_MAX = max4(W, CHAIN_LEN, LAT, CIPHER_TO);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] CL_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(CIPHER_TO);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vec_ready_q, vec_ready_d;
  logic [W-1:0]     resp_data_q, resp_data_d;
  logic             err_q, err_d;
  logic [W-1:0]     vec_q, vec_d;

  logic             sh_load, sh_out, sh_in;
  logic [W-1:0]     sh_q;

  scan_host_shreg #(.W(W)) u_shreg (
    .tck       (tck),
    .load      (sh_load),
    .shift_out (sh_out),
    .shift_in  (sh_in),
    .load_data (enc_out),
    .sin       (TDO),
    .q         (sh_q)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    sh_load     = 1'b0;
    sh_out      = 1'b0;
    sh_in       = 1'b0;
    enc_start   = 1'b0;
    dec_start   = 1'b0;
    enc_in      = '0;
    dec_in      = '0;
    TDI         = 1'b0;
    shift_en    = 1'b0;
    update_en   = 1'b0;
    capture_en  = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (vec_valid && vec_ready_q) begin
          vec_d   = vec_data;
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        // done is only meaningful after the start cycle; a done arriving on
        // the last allowed cycle still wins over the timeout
        enc_in    = vec_q;
        enc_start = (cnt_q == '0);
        if ((cnt_q != '0) && enc_done) begin
          sh_load = 1'b1;
          state_d = S_TX;
        end else if (cnt_q == TO_LAST) begin
          err_d       = 1'b1;
          resp_data_d = '0;
          state_d     = S_RESP;
        end
      end
      S_TX: begin
        TDI    = sh_q[W-1];
        sh_out = 1'b1;
        if (cnt_q == W_LAST) begin
          state_d = (LAT == 0) ? S_LOAD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_en = 1'b1;
        if (cnt_q == CL_LAST) state_d = S_UPD;
      end
      S_UPD: begin
        update_en = 1'b1;
        state_d   = S_CAP;
      end
      S_CAP: begin
        capture_en = 1'b1;
        state_d    = S_RX;
      end
      S_RX: begin
        shift_en = 1'b1;
        sh_in    = 1'b1;
        if (cnt_q == W_LAST) state_d = S_DEC;
      end
      S_DEC: begin
        dec_in    = sh_q;
        dec_start = (cnt_q == '0);
        if ((cnt_q != '0) && dec_done) begin
          err_d       = 1'b0;
          resp_data_d = dec_out;
          state_d     = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d       = 1'b1;
          resp_data_d = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (resp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // registered so that ready only rises one clock after reset release
    vec_ready_d = (state_d == S_IDLE);

    // counter restarts on every state change and saturates inside a state
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vec_ready_q <= 1'b0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_ready_q <= vec_ready_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge tck) begin
    vec_q <= vec_d;
  end

  assign vec_ready = vec_ready_q;
  assign resp_data = resp_data_q;

endmodule

// File: tb/tb_scan_host_crypt_driver.sv
// Bench for scan_host_crypt_driver: table of directed vectors run through a
// cipher model (XOR with a per-case key, configurable done latency, 0 = never)
// and a die loopback that replays the transmitted bits during the response
// shift, plus hand sequences for hold-off, mid-operation reset and stray done.
module tb_scan_host_crypt_driver;

  localparam int W  = 128;
  localparam int D  = 128 + 23 + 128 + 2; // TX bit k -> RX bit k distance
  localparam logic [127:0] K = 128'h0123456789abcdef0123456789abcdef;

  logic         tck = 1'b0;
  logic         reset;
  logic         vec_valid;
  logic         vec_ready;
  logic [W-1:0] vec_data;
  logic         enc_start, dec_start;
  logic [W-1:0] enc_in, dec_in;
  logic         enc_done, dec_done;
  logic [W-1:0] enc_out, dec_out;
  logic         TDI, TDO;
  logic         shift_en, update_en, capture_en;
  logic         resp_valid, resp_ready, resp_err;
  logic [W-1:0] resp_data;

  logic [127:0] key;
  int           enc_lat, dec_lat;
  int           enc_r, dec_r;
  logic         m_dec_done, stray_dec;
  logic [W-1:0] m_dec_out;
  logic [D-1:0] dl = '0;

  int checks = 0;
  int failures = 0;

  always #5 tck = ~tck;

  scan_host_crypt_driver dut (
    .tck(tck), .reset(reset),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .enc_start(enc_start), .enc_in(enc_in), .enc_done(enc_done), .enc_out(enc_out),
    .dec_start(dec_start), .dec_in(dec_in), .dec_done(dec_done), .dec_out(dec_out),
    .TDI(TDI), .TDO(TDO),
    .shift_en(shift_en), .update_en(update_en), .capture_en(capture_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  // cipher model: result = operand ^ key, done pulse lat cycles after start
  always @(posedge tck or posedge reset) begin
    if (reset) begin
      enc_r <= 0; dec_r <= 0;
      enc_done <= 1'b0; m_dec_done <= 1'b0;
      enc_out <= '0; m_dec_out <= '0;
    end else begin
      enc_done   <= 1'b0;
      m_dec_done <= 1'b0;
      if (enc_start) begin
        enc_out <= enc_in ^ key;
        if (enc_lat == 1) enc_done <= 1'b1;
        enc_r <= (enc_lat > 1) ? enc_lat - 1 : 0;
      end else if (enc_r > 0) begin
        enc_r <= enc_r - 1;
        if (enc_r == 1) enc_done <= 1'b1;
      end
      if (dec_start) begin
        m_dec_out <= dec_in ^ key;
        if (dec_lat == 1) m_dec_done <= 1'b1;
        dec_r <= (dec_lat > 1) ? dec_lat - 1 : 0;
      end else if (dec_r > 0) begin
        dec_r <= dec_r - 1;
        if (dec_r == 1) m_dec_done <= 1'b1;
      end
    end
  end

  assign dec_done = m_dec_done | stray_dec;
  assign dec_out  = stray_dec ? {W{1'b1}} : m_dec_out;

  // die loopback: TDO replays TDI from D cycles earlier
  always @(posedge tck) dl <= {dl[D-2:0], TDI};
  assign TDO = dl[D-1];

  typedef struct {
    logic [127:0] vec;
    logic [127:0] key;
    int           enc_lat;
    int           dec_lat;
    bit           stray;
    logic [127:0] exp_resp;
    logic         exp_err;
    logic [127:0] exp_tdi;
    int           exp_lat;
    int           exp_sh;
    int           exp_upd;
    int           exp_cap;
  } tv_t;

  tv_t tv[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (vec_ready !== 1'b1 && n < 50) begin
      @(negedge tck); n++;
    end
    chk("vec_ready_wait", {127'd0, vec_ready}, 128'd1);
  endtask

  task automatic run_case(input tv_t t, input int hold, input string tag);
    int cyc, done_cyc, ones, nsh, nup, ncap, bad1h, bad;
    logic [W-1:0] tdi_rec;
    logic [W-1:0] held;
    key = t.key; enc_lat = t.enc_lat; dec_lat = t.dec_lat;
    wait_ready();
    vec_valid = 1'b1; vec_data = t.vec;
    @(negedge tck);
    vec_valid = 1'b0;
    cyc = 1; done_cyc = -1; ones = 0; nsh = 0; nup = 0; ncap = 0; bad1h = 0;
    tdi_rec = '0;
    while (resp_valid !== 1'b1 && cyc < 4000) begin
      if (enc_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc > done_cyc && cyc <= done_cyc + W)
        tdi_rec = {tdi_rec[W-2:0], TDI};
      if (TDI === 1'b1) ones++;
      if (shift_en === 1'b1) nsh++;
      if (update_en === 1'b1) nup++;
      if (capture_en === 1'b1) ncap++;
      if (int'(shift_en) + int'(update_en) + int'(capture_en) > 1) bad1h++;
      stray_dec = t.stray && done_cyc >= 0 && cyc == done_cyc + 5;
      @(negedge tck);
      cyc++;
    end
    stray_dec = 1'b0;
    chk({tag, "_latency"}, 128'(cyc), 128'(t.exp_lat));
    chk({tag, "_resp_data"}, resp_data, t.exp_resp);
    chk({tag, "_resp_err"}, {127'd0, resp_err}, {127'd0, t.exp_err});
    chk({tag, "_tdi_bits"}, tdi_rec, t.exp_tdi);
    chk({tag, "_tdi_ones"}, 128'(ones), 128'($countones(t.exp_tdi)));
    chk({tag, "_shift_cnt"}, 128'(nsh), 128'(t.exp_sh));
    chk({tag, "_update_cnt"}, 128'(nup), 128'(t.exp_upd));
    chk({tag, "_capture_cnt"}, 128'(ncap), 128'(t.exp_cap));
    chk({tag, "_onehot_viol"}, 128'(bad1h), 128'd0);
    chk({tag, "_busy_ready"}, {127'd0, vec_ready}, 128'd0);
    if (hold > 0) begin
      held = resp_data;
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        vec_valid = 1'b1; vec_data = ~t.vec;
        @(negedge tck);
        if (resp_valid !== 1'b1 || resp_data !== held || vec_ready !== 1'b0 ||
            enc_start !== 1'b0 || resp_err !== t.exp_err) bad++;
      end
      vec_valid = 1'b0;
      chk({tag, "_hold_stable"}, 128'(bad), 128'd0);
    end
    resp_ready = 1'b1;
    @(negedge tck);
    resp_ready = 1'b0;
    chk({tag, "_resp_dropped"}, {127'd0, resp_valid}, 128'd0);
    chk({tag, "_ready_back"}, {127'd0, vec_ready}, 128'd1);
  endtask

  initial begin
    int n;
    tv[0] = '{{64{2'b10}}, 128'd0, 1, 1, 1'b0,
              {64{2'b10}}, 1'b0, {64{2'b10}}, 414, 256, 1, 1};
    tv[1] = '{128'd0, K, 5, 5, 1'b0,
              128'd0, 1'b0, K, 422, 256, 1, 1};
    tv[2] = '{128'h0123456789abcdef_fedcba9876543210, K, 1, 1, 1'b1,
              128'h0123456789abcdef_fedcba9876543210, 1'b0,
              128'h0000000000000000_ffffffffffffffff, 414, 256, 1, 1};
    tv[3] = '{{128{1'b1}}, 128'd0, 0, 1, 1'b0,
              128'd0, 1'b1, 128'd0, 1025, 0, 0, 0};
    tv[4] = '{{64{2'b01}}, K, 1, 0, 1'b0,
              128'd0, 1'b1, 128'h54761032dcfe98ba54761032dcfe98ba, 1436, 256, 1, 1};

    reset = 1'b1; vec_valid = 1'b0; vec_data = '0; resp_ready = 1'b0;
    stray_dec = 1'b0; key = '0; enc_lat = 1; dec_lat = 1;

    @(negedge tck);
    chk("rst_vec_ready", {127'd0, vec_ready}, 128'd0);
    chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
    chk("rst_resp_err", {127'd0, resp_err}, 128'd0);
    chk("rst_resp_data", resp_data, 128'd0);
    chk("rst_ctrl", {124'd0, TDI, shift_en, update_en, capture_en}, 128'd0);
    chk("rst_strobes", {126'd0, enc_start, dec_start}, 128'd0);
    reset = 1'b0;
    #1;
    chk("rel_ready_before_clk", {127'd0, vec_ready}, 128'd0);
    @(negedge tck);
    chk("rel_ready_after_clk", {127'd0, vec_ready}, 128'd1);

    for (int i = 0; i < 5; i++) run_case(tv[i], 0, $sformatf("tv%0d", i));

    // response held off, competing vector ignored, next vector accepted after
    run_case(tv[1], 50, "hold");
    run_case(tv[2], 0, "after_hold");

    // reset in the middle of the chain load
    key = '0; enc_lat = 1; dec_lat = 1;
    wait_ready();
    vec_valid = 1'b1; vec_data = tv[0].vec;
    @(negedge tck);
    vec_valid = 1'b0;
    n = 0;
    while (shift_en !== 1'b1 && n < 1000) begin
      @(negedge tck); n++;
    end
    chk("load_reached", {127'd0, shift_en}, 128'd1);
    repeat (10) @(negedge tck);
    #2 reset = 1'b1;
    #1;
    chk("midrst_shift_en", {127'd0, shift_en}, 128'd0);
    chk("midrst_outputs", {123'd0, TDI, update_en, capture_en, resp_valid, vec_ready}, 128'd0);
    chk("midrst_resp_data", resp_data, 128'd0);
    @(negedge tck);
    reset = 1'b0;
    run_case(tv[0], 0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
